serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 47 ++++
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor.
// Latency: none (wires only).
// Backpressure: none; the slave reports busy and ignores start while busy.
//
// Signals:
//   start, a, b, bin   requester -> subtractor (operands sampled on accepted start)
//   busy, done         subtractor status (busy during bit processing, done one cycle)
//   diff, bout, ovf    result, borrow-out and signed-overflow flag; valid when done=1
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // Requester side: drives the operation, observes status and result.
    modport master (
        output start,
        output a,
        output b,
        output bin,
        input  busy,
        input  done,
        input  diff,
        input  bout,
        input  ovf
    );

    // Subtractor side.
    modport slave (
        input  start,
        input  a,
        input  b,
        input  bin,
        output busy,
        output done,
        output diff,
        output bout,
        output ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clk edge, LSB first.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH.
// Backpressure: start ignored while busy; accepted in IDLE and in the DONE cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   serial_subtractor_if.slave: start/a/b/bin in, busy/done/diff/bout/ovf out
// Parameter WIDTH: operand and result width, legal range 2..32.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to produce the signed
// overflow flag on ovf; when undefined ovf is tied to 0 and no overflow
// logic exists.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    // Counter must be able to hold WIDTH itself (value after the final shift).
    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands are shifted right every SHIFT edge so bit 0 is always the
    // bit currently being processed.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic accept;
    logic last_bit;
    logic x;
    logic y;
    logic d;
    logic br_nxt;

    // A new request is taken whenever no bits are in flight.
    assign accept   = bus.start && (state != SHIFT);
    assign last_bit = (cnt == LAST);

    // One full-subtractor slice.
    assign x      = a_sh[0];
    assign y      = b_sh[0];
    assign d      = x ^ y ^ br;
    assign br_nxt = (~x & y) | (~(x ^ y) & br);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? SHIFT : IDLE;
            SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure function of state, so async reset clears them
    // immediately)
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            SHIFT:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else if (accept) begin
            // diff/bout keep the previous result until bits start arriving.
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            br     <= br_nxt;
            cnt    <= cnt + 1'b1;
            // Result bits enter at the MSB; after WIDTH shifts the first
            // (LSB) result bit has walked down to bit 0.
            diff_r <= {d, diff_r[WIDTH-1:1]};
            if (last_bit) begin
                bout_r <= br_nxt;
            end
        end
    end

    assign bus.diff = diff_r;
    assign bus.bout = bout_r;

`ifdef SERIAL_SUB_OVERFLOW_EN
    // The shifted operand copies lose their sign bits, so the signs are
    // captured separately at accept time.
    logic a_msb;
    logic b_msb;
    logic ovf_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if ((state == SHIFT) && last_bit) begin
            // On the final edge d is the sign bit of the result.
            ovf_r <= (a_msb != b_msb) && (d != a_msb);
        end
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule
